edge_stream_detector: RTL and testbench

Streaming, parametrised successor to the fixed 8-bit edge detection core. Accepts one raster-order frame of IMG_W x IMG_H pixels over a valid/ready handshake and buffers two rows internally. Per pixel it emits one gradient result (|right-left| + |down-up|) as magnitude, thresholded binary, or a single direction, with backpressure support and a frame-complete pulse. It sits between the pixel source (file streamer / smoothing filter) and the post-detection filter.

---
 rtl/edge_pkg.sv | 41 ++++
 rtl/edge_line_buffer.sv | 63 ++++++
 rtl/edge_stream_detector.sv | 204 ++++++++++++++++++++
 tb/tb_edge_stream_detector.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared definitions for the streaming edge detector.
//   - MODE_* : output selection encodings for the 2-bit mode input
//   - state_t: frame-level control states
//   - abs_diff / sat_add: unsigned helpers evaluated at MAX_W bits; callers
//     zero-extend their operands and cast the result back to their width.
package edge_pkg;

    localparam logic [1:0] MODE_MAG = 2'b00;
    localparam logic [1:0] MODE_BIN = 2'b01;
    localparam logic [1:0] MODE_H   = 2'b10;
    localparam logic [1:0] MODE_V   = 2'b11;

    // Widest pixel the helpers support.
    localparam int MAX_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH,
        DONE
    } state_t;

    function automatic logic [MAX_W-1:0] abs_diff(input logic [MAX_W-1:0] a,
                                                  input logic [MAX_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // a + b clamped to the largest value representable in w bits (w <= MAX_W).
    function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input int unsigned      w);
        localparam logic [MAX_W:0] SAT_ONE = {{MAX_W{1'b0}}, 1'b1};
        logic [MAX_W:0] s;
        logic [MAX_W:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = (SAT_ONE << w) - SAT_ONE;
        return (s > lim) ? lim[MAX_W-1:0] : s[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/edge_line_buffer.sv
// Two-row-plus-two circular pixel buffer for the edge detector.
// Ports:
//   clk, reset (async, active-low) : clock / pointer reset
//   shift                          : write din and advance one pixel
//   din                            : incoming pixel
//   centre, left, right, up, down  : neighbourhood of the pixel written
//                                    IMG_W+1 shifts ago, read before the
//                                    current write lands
module edge_line_buffer #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] centre,
    output logic [DATA_W-1:0] left,
    output logic [DATA_W-1:0] right,
    output logic [DATA_W-1:0] up,
    output logic [DATA_W-1:0] down
);

    localparam int DEPTH = 2 * IMG_W + 2;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;

    always_ff @(posedge clk) begin
        if (shift) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
        end else if (shift) begin
            wptr <= (wptr == PTR_LAST) ? '0 : wptr + PTR_W'(1);
        end
    end

    // Slot holding the pixel written 'age' shifts ago (age 1 = newest).
    function automatic logic [PTR_W-1:0] tap_idx(input logic [PTR_W-1:0] wp,
                                                 input int               age);
        int p;
        p = int'(wp) - age;
        if (p < 0) begin
            p = p + DEPTH;
        end
        return PTR_W'(p);
    endfunction

    // With j the pixel about to be written, the centre is j-IMG_W-1.
    assign down   = mem[tap_idx(wptr, 1)];
    assign right  = mem[tap_idx(wptr, IMG_W)];
    assign centre = mem[tap_idx(wptr, IMG_W + 1)];
    assign left   = mem[tap_idx(wptr, IMG_W + 2)];
    assign up     = mem[tap_idx(wptr, 2 * IMG_W + 1)];

endmodule

// File: rtl/edge_stream_detector.sv
// Streaming gradient edge detector for one raster-order IMG_W x IMG_H frame.
// Ports:
//   clk, reset (async, active-low)
//   enb       : enable for input acceptance and output generation
//   clear     : synchronous frame abort back to IDLE
//   mode      : 00 magnitude, 01 threshold, 10 horizontal, 11 vertical
//   thresh    : threshold for mode 01
//   in_valid / in_ready / in_data    : pixel input handshake
//   out_valid / out_ready / out_data : result output handshake
//   out_last  : flags the final result of the frame
//   busy      : high whenever not IDLE
//   complete  : one-cycle pulse after the final output transfer
module edge_stream_detector
    import edge_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enb,
    input  logic              clear,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] thresh,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              complete
);

    localparam int N     = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(N + 1);
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);

    localparam logic [CNT_W-1:0] CNT_W_END = CNT_W'(IMG_W);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_N     = CNT_W'(N);
    localparam logic [XW-1:0]    X_LAST    = XW'(IMG_W - 1);
    localparam logic [YW-1:0]    Y_LAST    = YW'(IMG_H - 1);

    state_t            state;
    logic [CNT_W-1:0]  in_cnt;
    logic [CNT_W-1:0]  out_cnt;
    logic [XW-1:0]     ox;
    logic [YW-1:0]     oy;
    logic [1:0]        mode_q;

    logic [DATA_W-1:0] tap_left, tap_right, tap_up, tap_down;
    // The centre pixel does not enter a central-difference gradient.
    logic [DATA_W-1:0] tap_centre_unused;

    logic              in_fire, out_fire, slot_free;
    logic              gen_run, gen_flush, gen;
    logic              border_p0;
    logic [DATA_W-1:0] gx_p0, gy_p0;
    logic [DATA_W:0]   sum_p0;
    logic [DATA_W-1:0] res_p0;

    edge_line_buffer #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W)
    ) u_line_buffer (
        .clk    (clk),
        .reset  (reset),
        .shift  (in_fire),
        .din    (in_data),
        .centre (tap_centre_unused),
        .left   (tap_left),
        .right  (tap_right),
        .up     (tap_up),
        .down   (tap_down)
    );

    // Held low during clear so an aborted cycle never consumes a pixel.
    always_comb begin
        in_ready = 1'b0;
        if (reset && enb && !clear) begin
            case (state)
                IDLE, FILL: in_ready = 1'b1;
                RUN:        in_ready = !out_valid || out_ready;
                default:    in_ready = 1'b0;
            endcase
        end
    end

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign slot_free = !out_valid || out_ready;
    assign busy      = (state != IDLE);

    // RUN emits one result per accepted pixel; FLUSH drains the tail on its own.
    assign gen_run   = (state == RUN) && in_fire;
    assign gen_flush = (state == FLUSH) && enb && !clear && slot_free && (out_cnt != CNT_N);
    assign gen       = gen_run || gen_flush;

    // ---- stage p0: gradient of output pixel (ox, oy) from the taps ----
    always_comb begin
        border_p0 = (ox == '0) || (ox == X_LAST) || (oy == '0) || (oy == Y_LAST);
        gx_p0     = DATA_W'(abs_diff(MAX_W'(tap_right), MAX_W'(tap_left)));
        gy_p0     = DATA_W'(abs_diff(MAX_W'(tap_down), MAX_W'(tap_up)));
        sum_p0    = {1'b0, gx_p0} + {1'b0, gy_p0};
        case (mode_q)
            MODE_MAG: res_p0 = DATA_W'(sat_add(MAX_W'(gx_p0), MAX_W'(gy_p0), DATA_W));
            MODE_BIN: res_p0 = (sum_p0 >= {1'b0, thresh}) ? '1 : '0;
            MODE_H:   res_p0 = gx_p0;
            MODE_V:   res_p0 = gy_p0;
            default:  res_p0 = '0;
        endcase
        if (state != RUN || border_p0) begin
            res_p0 = '0;
        end
    end

    // ---- stage p1: registered output and frame control ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            in_cnt    <= '0;
            out_cnt   <= '0;
            ox        <= '0;
            oy        <= '0;
            mode_q    <= MODE_MAG;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            complete  <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            in_cnt    <= '0;
            out_cnt   <= '0;
            ox        <= '0;
            oy        <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            complete  <= 1'b0;
        end else begin
            complete <= 1'b0;

            if (gen) begin
                out_valid <= 1'b1;
                out_data  <= res_p0;
                out_last  <= (out_cnt == CNT_LAST);
                out_cnt   <= out_cnt + CNT_W'(1);
                if (ox == X_LAST) begin
                    ox <= '0;
                    oy <= (oy == Y_LAST) ? '0 : oy + YW'(1);
                end else begin
                    ox <= ox + XW'(1);
                end
            end else if (out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (in_fire) begin
                        mode_q <= mode;
                        in_cnt <= CNT_W'(1);
                        state  <= FILL;
                    end
                end
                FILL: begin
                    if (in_fire) begin
                        in_cnt <= in_cnt + CNT_W'(1);
                        if (in_cnt == CNT_W_END) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (in_fire) begin
                        in_cnt <= in_cnt + CNT_W'(1);
                        if (in_cnt == CNT_LAST) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (out_fire && out_last) begin
                        state    <= DONE;
                        complete <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    in_cnt  <= '0;
                    out_cnt <= '0;
                    ox      <= '0;
                    oy      <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_edge_stream_detector.sv
module tb_edge_stream_detector;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       reset, enb, clear;
    logic [1:0] mode;
    logic [7:0] thresh, in_data, out_data;
    logic       in_valid, in_ready, out_valid, out_ready, out_last, busy, complete;

    int checks = 0;
    int errors = 0;

    logic [7:0] cur_img [N];
    logic [7:0] got_data [$];
    logic       got_last [$];
    int         n_cpl, bp_viol, timed_out;

    edge_stream_detector #(
        .DATA_W (8),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enb       (enb),
        .clear     (clear),
        .mode      (mode),
        .thresh    (thresh),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .complete  (complete)
    );

    always #5 clk = ~clk;

    // kind 0: ramp 10x+20y, kind 1: step, otherwise random
    task automatic fill_image(input int kind);
        for (int k = 0; k < N; k++) begin
            int x, y;
            x = k % W;
            y = k / W;
            case (kind)
                0:       cur_img[k] = 8'(10 * x + 20 * y);
                1:       cur_img[k] = (x >= 2 || y >= 2) ? 8'd255 : 8'd0;
                default: cur_img[k] = 8'($urandom);
            endcase
        end
    endtask

    // Reference result for pixel k from the neighbour definition of the gradient.
    function automatic int ref_pixel(input int k, input int m, input int th);
        int x, y, gx, gy;
        x = k % W;
        y = k / W;
        if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return 0;
        gx = int'(cur_img[k + 1]) - int'(cur_img[k - 1]);
        if (gx < 0) gx = -gx;
        gy = int'(cur_img[k + W]) - int'(cur_img[k - W]);
        if (gy < 0) gy = -gy;
        case (m)
            0:       return (gx + gy > 255) ? 255 : gx + gy;
            1:       return (gx + gy >= th) ? 255 : 0;
            2:       return gx;
            default: return gy;
        endcase
    endfunction

    // Streams cur_img and records every output transfer until complete.
    // rdy_kind: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    task automatic run_frame(input int fmode, input logic [7:0] fthr,
                             input int rdy_kind, input bit vrand);
        int idx, cyc;
        bit fin;
        idx = 0; cyc = 0; fin = 0;
        got_data.delete();
        got_last.delete();
        n_cpl = 0; bp_viol = 0; timed_out = 0;
        thresh = fthr;
        while (!fin) begin
            @(negedge clk);
            in_valid = (idx < N) && (!vrand || ($urandom_range(0, 2) != 0));
            in_data  = (idx < N) ? cur_img[idx] : 8'($urandom);
            mode     = (idx == 0) ? 2'(fmode) : 2'($urandom);
            case (rdy_kind)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (out_valid && !out_ready && in_ready) bp_viol++;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
            end
            if (complete) begin
                n_cpl++;
                fin = 1;
            end
            if (in_valid && in_ready) idx++;
            cyc++;
            if (cyc > 600) begin
                timed_out = 1;
                fin = 1;
            end
        end
        in_valid = 1'b0;
        if (timed_out != 0) begin
            @(negedge clk);
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
        end
    endtask

    // Feeds pixels 0..cnt-1 with out_ready high; returns how many were accepted.
    task automatic feed_pixels(input int cnt, output int accepted);
        int idx, cyc;
        idx = 0; cyc = 0;
        out_ready = 1'b1;
        while (idx < cnt && cyc < 200) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = cur_img[idx];
            #1;
            if (in_ready) idx++;
            cyc++;
        end
        accepted = idx;
    endtask

    task automatic test_reset();
        reset = 1'b0; enb = 1'b1; clear = 1'b0; mode = 2'b00; thresh = 8'd0;
        in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 8'd0)  begin errors++; $display("FAIL rst_out_data got %0d want 0", out_data); end
        checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL rst_out_last got %b want 0", out_last); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (complete !== 1'b0)  begin errors++; $display("FAIL rst_complete got %b want 0", complete); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_modes();
        for (int c = 0; c < 9; c++) begin
            int kind, m, kidx, kval;
            logic [7:0] th;
            string name;
            kidx = -1; kval = 0; th = 8'd0;
            case (c)
                0: begin kind = 0; m = 0; kidx = 5;  kval = 60;  end
                1: begin kind = 0; m = 1; th = 8'd60; kidx = 10; kval = 255; end
                2: begin kind = 0; m = 1; th = 8'd61; kidx = 10; kval = 0;   end
                3: begin kind = 0; m = 2; kidx = 6;  kval = 20;  end
                4: begin kind = 0; m = 3; kidx = 9;  kval = 40;  end
                5: begin kind = 1; m = 0; kidx = 5;  kval = 255; end
                6: begin kind = 1; m = 0; kidx = 6;  kval = 255; end
                default: begin kind = 2; m = $urandom_range(0, 3); th = 8'($urandom); end
            endcase
            name = $sformatf("mode_case%0d", c);
            fill_image(kind);
            run_frame(m, th, 0, 0);
            checks++; if (timed_out !== 0) begin errors++; $display("FAIL %s timeout got %0d want 0", name, timed_out); end
            checks++; if (got_data.size() !== N) begin errors++; $display("FAIL %s count got %0d want %0d", name, got_data.size(), N); end
            for (int i = 0; i < got_data.size() && i < N; i++) begin
                logic [7:0] e;
                e = 8'(ref_pixel(i, m, int'(th)));
                checks++; if (got_data[i] !== e) begin errors++; $display("FAIL %s pix[%0d] got %0d want %0d", name, i, got_data[i], e); end
                checks++; if (got_last[i] !== (i == N - 1)) begin errors++; $display("FAIL %s last[%0d] got %b want %b", name, i, got_last[i], (i == N - 1)); end
            end
            if (kidx >= 0 && got_data.size() > kidx) begin
                checks++; if (got_data[kidx] !== 8'(kval)) begin errors++; $display("FAIL %s known[%0d] got %0d want %0d", name, kidx, got_data[kidx], kval); end
            end
            checks++; if (n_cpl !== 1) begin errors++; $display("FAIL %s complete got %0d want 1", name, n_cpl); end
        end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 3; c++) begin
            int m;
            string name;
            name = $sformatf("bp_case%0d", c);
            m = (c == 0) ? 0 : $urandom_range(0, 3);
            fill_image((c == 0) ? 0 : 2);
            run_frame(m, 8'd100, (c == 2) ? 2 : 1, 1);
            checks++; if (timed_out !== 0) begin errors++; $display("FAIL %s timeout got %0d want 0", name, timed_out); end
            checks++; if (bp_viol !== 0) begin errors++; $display("FAIL %s in_ready_under_stall got %0d want 0", name, bp_viol); end
            checks++; if (got_data.size() !== N) begin errors++; $display("FAIL %s count got %0d want %0d", name, got_data.size(), N); end
            for (int i = 0; i < got_data.size() && i < N; i++) begin
                logic [7:0] e;
                e = 8'(ref_pixel(i, m, 100));
                checks++; if (got_data[i] !== e) begin errors++; $display("FAIL %s pix[%0d] got %0d want %0d", name, i, got_data[i], e); end
                checks++; if (got_last[i] !== (i == N - 1)) begin errors++; $display("FAIL %s last[%0d] got %b want %b", name, i, got_last[i], (i == N - 1)); end
            end
            checks++; if (n_cpl !== 1) begin errors++; $display("FAIL %s complete got %0d want 1", name, n_cpl); end
        end
    endtask

    task automatic test_clear();
        int acc, cpl;
        fill_image(0);
        mode = 2'b00;
        feed_pixels(10, acc);
        checks++; if (acc !== 10) begin errors++; $display("FAIL clr_fed got %0d want 10", acc); end
        @(negedge clk);
        clear = 1'b1;
        in_valid = 1'b1;
        in_data = cur_img[10];
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_out_valid got %b want 0", out_valid); end
        checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL clr_out_last got %b want 0", out_last); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL clr_busy got %b want 0", busy); end
        cpl = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (complete) cpl++;
        end
        checks++; if (cpl !== 0) begin errors++; $display("FAIL clr_complete got %0d want 0", cpl); end
        fill_image(0);
        run_frame(0, 8'd0, 2, 1);
        checks++; if (timed_out !== 0) begin errors++; $display("FAIL clr_frame timeout got %0d want 0", timed_out); end
        checks++; if (got_data.size() !== N) begin errors++; $display("FAIL clr_frame count got %0d want %0d", got_data.size(), N); end
        for (int i = 0; i < got_data.size() && i < N; i++) begin
            logic [7:0] e;
            e = 8'(ref_pixel(i, 0, 0));
            checks++; if (got_data[i] !== e) begin errors++; $display("FAIL clr_frame pix[%0d] got %0d want %0d", i, got_data[i], e); end
        end
        checks++; if (n_cpl !== 1) begin errors++; $display("FAIL clr_frame complete got %0d want 1", n_cpl); end
    endtask

    task automatic test_reset_flush();
        int acc;
        fill_image(0);
        mode = 2'b00;
        feed_pixels(N, acc);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++; if (acc !== N)         begin errors++; $display("FAIL rf_fed got %0d want %0d", acc, N); end
        checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL rf_flush_busy got %b want 1", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rf_flush_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rf_flush_out_valid got %b want 1", out_valid); end
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rf_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 8'd0)  begin errors++; $display("FAIL rf_out_data got %0d want 0", out_data); end
        checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL rf_out_last got %b want 0", out_last); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rf_busy got %b want 0", busy); end
        checks++; if (complete !== 1'b0)  begin errors++; $display("FAIL rf_complete got %b want 0", complete); end
        @(negedge clk);
        reset = 1'b1;
        enb = 1'b0;
        in_valid = 1'b1;
        in_data = 8'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL enb_low_in_ready[%0d] got %b want 0", i, in_ready); end
            checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL enb_low_busy[%0d] got %b want 0", i, busy); end
        end
        in_valid = 1'b0;
        enb = 1'b1;
        run_frame(0, 8'd0, 0, 0);
        checks++; if (timed_out !== 0) begin errors++; $display("FAIL rf_frame timeout got %0d want 0", timed_out); end
        checks++; if (got_data.size() !== N) begin errors++; $display("FAIL rf_frame count got %0d want %0d", got_data.size(), N); end
        for (int i = 0; i < got_data.size() && i < N; i++) begin
            logic [7:0] e;
            e = 8'(ref_pixel(i, 0, 0));
            checks++; if (got_data[i] !== e) begin errors++; $display("FAIL rf_frame pix[%0d] got %0d want %0d", i, got_data[i], e); end
        end
        checks++; if (n_cpl !== 1) begin errors++; $display("FAIL rf_frame complete got %0d want 1", n_cpl); end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            int m;
            logic [7:0] th;
            m = $urandom_range(0, 3);
            th = 8'($urandom);
            fill_image(2);
            run_frame(m, th, 2, 0);
            checks++; if (timed_out !== 0) begin errors++; $display("FAIL b2b%0d timeout got %0d want 0", f, timed_out); end
            checks++; if (got_data.size() !== N) begin errors++; $display("FAIL b2b%0d count got %0d want %0d", f, got_data.size(), N); end
            for (int i = 0; i < got_data.size() && i < N; i++) begin
                logic [7:0] e;
                e = 8'(ref_pixel(i, m, int'(th)));
                checks++; if (got_data[i] !== e) begin errors++; $display("FAIL b2b%0d pix[%0d] got %0d want %0d", f, i, got_data[i], e); end
                checks++; if (got_last[i] !== (i == N - 1)) begin errors++; $display("FAIL b2b%0d last[%0d] got %b want %b", f, i, got_last[i], (i == N - 1)); end
            end
            checks++; if (n_cpl !== 1) begin errors++; $display("FAIL b2b%0d complete got %0d want 1", f, n_cpl); end
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_backpressure();
        test_clear();
        test_reset_flush();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
